// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage in-order pipeline.
// Tracks in-flight destinations for EX, MEM and WB and stalls on RAW hazards
// (no forwarding), flushes on redirects and freezes while memory is busy.
// Optional feature macro: HZD_WB_CHECK_EN (WB entry also takes part in matching,
// for a register file without write-before-read).
// All state changes on the falling edge of clk_HZD.
module hazard_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_HZD,
    input  logic            rstn_HZD,
    input  logic            valid_ID,
    input  logic [4:0]      Rs1_addr_ID,
    input  logic [4:0]      Rs2_addr_ID,
    input  logic            Rs1_used_ID,
    input  logic            Rs2_used_ID,
    input  logic [4:0]      Rd_addr_ID,
    input  logic            RegWrite_ID,
    input  logic            redirect_EX,
    input  logic            mem_busy,
    output logic            en_PC,
    output logic            en_IFID,
    output logic            NOP_IFID,
    output logic            en_IDEX,
    output logic            NOP_IDEX,
    output logic            raw_hazard,
    output logic [XLEN-1:0] stall_cnt,
    output logic [XLEN-1:0] flush_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    sb_entry_t       r_sb_ex, r_sb_mem, r_sb_wb;
    logic [XLEN-1:0] r_stall_cnt, r_flush_cnt;

    logic w_match_ex, w_match_mem, w_match_wb;
    logic w_hazard, w_flush, w_stall;

    // x0 never matches, neither as source nor as a recorded destination.
    function automatic logic src_match(input logic used, input logic [4:0] addr,
                                       input sb_entry_t e);
        return used && (addr != 5'd0) && e.v && (e.rd == addr);
    endfunction

    // Hazard detection against the scoreboard entries.
    always_comb begin
        w_match_ex  = src_match(Rs1_used_ID, Rs1_addr_ID, r_sb_ex)
                   || src_match(Rs2_used_ID, Rs2_addr_ID, r_sb_ex);
        w_match_mem = src_match(Rs1_used_ID, Rs1_addr_ID, r_sb_mem)
                   || src_match(Rs2_used_ID, Rs2_addr_ID, r_sb_mem);
`ifdef HZD_WB_CHECK_EN
        w_match_wb  = src_match(Rs1_used_ID, Rs1_addr_ID, r_sb_wb)
                   || src_match(Rs2_used_ID, Rs2_addr_ID, r_sb_wb);
`else
        w_match_wb  = 1'b0;
`endif
        w_hazard = valid_ID && (w_match_ex || w_match_mem || w_match_wb);
        // Freeze outranks flush, flush outranks stall.
        w_flush  = !mem_busy && redirect_EX;
        w_stall  = !mem_busy && !redirect_EX && w_hazard;
    end

`ifndef HZD_WB_CHECK_EN
    // WB is tracked but never consulted in this build.
    logic w_unused_sb_wb;
    assign w_unused_sb_wb = ^r_sb_wb;
`endif

    // Pipeline register controls; reset forces plain flow with no bubbles.
    always_comb begin
        en_PC      = 1'b1;
        en_IFID    = 1'b1;
        en_IDEX    = 1'b1;
        NOP_IFID   = 1'b0;
        NOP_IDEX   = 1'b0;
        raw_hazard = 1'b0;
        if (rstn_HZD) begin
            raw_hazard = w_hazard;
            if (mem_busy) begin
                en_PC   = 1'b0;
                en_IFID = 1'b0;
                en_IDEX = 1'b0;
            end else if (redirect_EX) begin
                NOP_IFID = 1'b1;
                NOP_IDEX = 1'b1;
            end else if (w_hazard) begin
                en_PC    = 1'b0;
                en_IFID  = 1'b0;
                NOP_IDEX = 1'b1;
            end
        end
    end

    // Scoreboard shift and saturating counters; everything holds while frozen.
    always_ff @(negedge clk_HZD or negedge rstn_HZD) begin
        if (!rstn_HZD) begin
            r_sb_ex     <= '0;
            r_sb_mem    <= '0;
            r_sb_wb     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_busy) begin
            r_sb_wb    <= r_sb_mem;
            r_sb_mem   <= r_sb_ex;
            // A bubble enters EX on flush or stall.
            r_sb_ex.v  <= valid_ID && RegWrite_ID && (Rd_addr_ID != 5'd0)
                       && !w_flush && !w_stall;
            r_sb_ex.rd <= Rd_addr_ID;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + XLEN'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + XLEN'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_hazard_ctrl;

`ifdef HZD_WB_CHECK_EN
    localparam int NCHK = 3;
`else
    localparam int NCHK = 2;
`endif
    localparam int EXP_STALL = NCHK;

    logic        clk_HZD = 1'b1;
    logic        rstn_HZD = 1'b0;
    logic        valid_ID = 1'b0;
    logic [4:0]  Rs1_addr_ID = '0, Rs2_addr_ID = '0, Rd_addr_ID = '0;
    logic        Rs1_used_ID = 1'b0, Rs2_used_ID = 1'b0, RegWrite_ID = 1'b0;
    logic        redirect_EX = 1'b0, mem_busy = 1'b0;
    logic        en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, raw_hazard;
    logic [31:0] stall_cnt, flush_cnt;

    // Second instance with 2-bit counters to reach saturation quickly.
    logic        s_en_PC, s_en_IFID, s_NOP_IFID, s_en_IDEX, s_NOP_IDEX, s_raw;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk_HZD = ~clk_HZD;

    hazard_ctrl #(.XLEN(32)) u_dut (
        .clk_HZD(clk_HZD), .rstn_HZD(rstn_HZD), .valid_ID(valid_ID),
        .Rs1_addr_ID(Rs1_addr_ID), .Rs2_addr_ID(Rs2_addr_ID),
        .Rs1_used_ID(Rs1_used_ID), .Rs2_used_ID(Rs2_used_ID),
        .Rd_addr_ID(Rd_addr_ID), .RegWrite_ID(RegWrite_ID),
        .redirect_EX(redirect_EX), .mem_busy(mem_busy),
        .en_PC(en_PC), .en_IFID(en_IFID), .NOP_IFID(NOP_IFID),
        .en_IDEX(en_IDEX), .NOP_IDEX(NOP_IDEX), .raw_hazard(raw_hazard),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Producer of x5 that also reads x5: stalls repeatedly, never redirected.
    hazard_ctrl #(.XLEN(2)) u_sat (
        .clk_HZD(clk_HZD), .rstn_HZD(rstn_HZD), .valid_ID(1'b1),
        .Rs1_addr_ID(5'd5), .Rs2_addr_ID(5'd0),
        .Rs1_used_ID(1'b1), .Rs2_used_ID(1'b0),
        .Rd_addr_ID(5'd5), .RegWrite_ID(1'b1),
        .redirect_EX(1'b0), .mem_busy(1'b0),
        .en_PC(s_en_PC), .en_IFID(s_en_IFID), .NOP_IFID(s_NOP_IFID),
        .en_IDEX(s_en_IDEX), .NOP_IDEX(s_NOP_IDEX), .raw_hazard(s_raw),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Destinations of the last three instructions to enter EX, newest first;
    // 0 stands for a bubble or a non-writing instruction.
    int          inflight[$] = '{0, 0, 0};
    logic [63:0] m_stall = 0, m_flush = 0;

    function automatic bit model_hazard();
        bit h = 0;
        for (int i = 0; i < NCHK; i++) begin
            if (inflight[i] != 0) begin
                if (Rs1_used_ID && int'(Rs1_addr_ID) == inflight[i]) h = 1;
                if (Rs2_used_ID && int'(Rs2_addr_ID) == inflight[i]) h = 1;
            end
        end
        return valid_ID && h;
    endfunction

    always @(negedge clk_HZD or negedge rstn_HZD) begin
        if (!rstn_HZD) begin
            inflight = '{0, 0, 0};
            m_stall  = 0;
            m_flush  = 0;
        end else if (!mem_busy) begin
            bit flush, stall;
            int nd;
            flush = redirect_EX;
            stall = !redirect_EX && model_hazard();
            nd = (valid_ID && RegWrite_ID && !flush && !stall) ? int'(Rd_addr_ID) : 0;
            inflight.push_front(nd);
            void'(inflight.pop_back());
            if (flush && m_flush < 64'hFFFF_FFFF) m_flush++;
            if (stall && m_stall < 64'hFFFF_FFFF) m_stall++;
        end
    end

    // Single compare process, mid-way between the edges.
    always @(posedge clk_HZD) begin
        logic [5:0] exp_ctrl;
        bit hz;
        #3;
        hz = model_hazard();
        if (!rstn_HZD)          exp_ctrl = 6'b110100;
        else if (mem_busy)      exp_ctrl = {5'b00000, hz};
        else if (redirect_EX)   exp_ctrl = {5'b11111, hz};
        else if (hz)            exp_ctrl = 6'b000111;
        else                    exp_ctrl = 6'b110100;
        check("ctrl{enPC,enIFID,nopIFID,enIDEX,nopIDEX,raw}",
              {58'd0, en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, raw_hazard},
              {58'd0, exp_ctrl});
        check("stall_cnt", {32'd0, stall_cnt}, m_stall);
        check("flush_cnt", {32'd0, flush_cnt}, m_flush);
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input int rd, input bit rw, input bit redir,
                          input bit busy);
        valid_ID    = v;
        Rs1_addr_ID = 5'(rs1);  Rs1_used_ID = u1;
        Rs2_addr_ID = 5'(rs2);  Rs2_used_ID = u2;
        Rd_addr_ID  = 5'(rd);   RegWrite_ID = rw;
        redirect_EX = redir;    mem_busy    = busy;
    endtask

    // Next cycle: inputs change 1 time unit after the rising edge.
    task automatic cyc(input bit v, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit rw, input bit redir,
                       input bit busy);
        @(posedge clk_HZD);
        #1 set_in(v, rs1, u1, rs2, u2, rd, rw, redir, busy);
    endtask

    // Holds current inputs and counts hazard cycles; returns at +4 of the first clear cycle.
    task automatic wait_stall(output int n);
        bit done = 0;
        n = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            #3;
            if (!raw_hazard) begin
                done = 1;
            end else begin
                n++;
                check("stall_en_PC", {63'd0, en_PC}, 64'd0);
                check("stall_NOP_IDEX", {63'd0, NOP_IDEX}, 64'd1);
                @(posedge clk_HZD);
                #1;
            end
        end
        if (!done) check("stall_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk_HZD);
        #3;
        check("reset_en_PC", {63'd0, en_PC}, 64'd1);
        check("reset_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        #1 rstn_HZD = 1'b1;

        // addi x5,x0,1 ; add x6,x5,x5
        cyc(1, 0, 1, 0, 0, 5, 1, 0, 0);
        cyc(1, 5, 1, 5, 1, 6, 1, 0, 0);
        wait_stall(n);
        check("raw_stall_len", n, EXP_STALL);
        check("raw_stall_cnt", {32'd0, stall_cnt}, EXP_STALL);

        // addi x0,x0,1 ; add x6,x0,x0
        cyc(1, 0, 1, 0, 0, 0, 1, 0, 0);
        #3 check("x0_dst_raw", {63'd0, raw_hazard}, 64'd0);
        cyc(1, 0, 1, 0, 1, 6, 1, 0, 0);
        #3 check("x0_src_raw", {63'd0, raw_hazard}, 64'd0);
        check("x0_stall_cnt", {32'd0, stall_cnt}, EXP_STALL);

        // Redirect pulse kills the x7 writer in ID.
        cyc(1, 0, 0, 0, 0, 7, 1, 1, 0);
        #3 check("redir_NOP_IFID", {63'd0, NOP_IFID}, 64'd1);
        check("redir_NOP_IDEX", {63'd0, NOP_IDEX}, 64'd1);
        check("redir_en_PC", {63'd0, en_PC}, 64'd1);
        cyc(1, 7, 1, 0, 0, 0, 0, 0, 0);
        #3 check("post_redir_NOP_IFID", {63'd0, NOP_IFID}, 64'd0);
        check("post_redir_raw", {63'd0, raw_hazard}, 64'd0);
        check("flush_cnt_1", {32'd0, flush_cnt}, 64'd1);

        // Hazard interrupted by a 4-cycle freeze.
        cyc(1, 0, 1, 0, 0, 9, 1, 0, 0);
        cyc(1, 9, 1, 0, 0, 10, 1, 0, 0);
        #3 check("frz_first_raw", {63'd0, raw_hazard}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 9, 1, 0, 0, 10, 1, 0, 1);
            #3 check("frz_en", {61'd0, en_PC, en_IFID, en_IDEX}, 64'd0);
            check("frz_nop", {62'd0, NOP_IFID, NOP_IDEX}, 64'd0);
            check("frz_stall_cnt", {32'd0, stall_cnt}, EXP_STALL + 1);
        end
        cyc(1, 9, 1, 0, 0, 10, 1, 0, 0);
        wait_stall(n);
        check("frz_remaining", n, EXP_STALL - 1);
        check("frz_stall_cnt_end", {32'd0, stall_cnt}, 2 * EXP_STALL);

        // Redirect coinciding with a hazard counts as a flush only.
        cyc(1, 0, 1, 0, 0, 11, 1, 0, 0);
        cyc(1, 11, 1, 0, 0, 12, 1, 1, 0);
        #3 check("rh_NOP_IFID", {63'd0, NOP_IFID}, 64'd1);
        check("rh_en_PC", {63'd0, en_PC}, 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3 check("rh_flush_cnt", {32'd0, flush_cnt}, 64'd2);
        check("rh_stall_cnt", {32'd0, stall_cnt}, 2 * EXP_STALL);

        check("sat_stall_cnt", {62'd0, s_stall_cnt}, 64'd3);
        check("sat_flush_cnt", {62'd0, s_flush_cnt}, 64'd0);

        // Reset between edges in the middle of a stall.
        cyc(1, 0, 1, 0, 0, 13, 1, 0, 0);
        cyc(1, 13, 1, 0, 0, 14, 1, 0, 0);
        #1 rstn_HZD = 1'b0;
        #1 check("rst_en", {61'd0, en_PC, en_IFID, en_IDEX}, 64'd7);
        check("rst_nop_raw", {61'd0, NOP_IFID, NOP_IDEX, raw_hazard}, 64'd0);
        check("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        check("rst_flush_cnt", {32'd0, flush_cnt}, 64'd0);
        #4 rstn_HZD = 1'b1;

        // Randomized traffic with small register indices to provoke matches.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(7, 0) != 0), $urandom_range(7, 0), $urandom_range(1, 0),
                $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(7, 0),
                $urandom_range(1, 0), ($urandom_range(9, 0) == 0),
                ($urandom_range(5, 0) == 0));
            if ($urandom_range(99, 0) == 0) begin
                #1 rstn_HZD = 1'b0;
                #5 rstn_HZD = 1'b1;
            end
        end

        @(posedge clk_HZD);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller for the 5-stage in-order RISC-V pipeline. It produces the enable and NOP (bubble) controls that the PC, IF/ID and ID/EX pipeline registers consume. It keeps its own scoreboard of in-flight destination registers for EX, MEM and WB, so read-after-write hazards are resolved by stalling; there is no forwarding. It also flushes on taken branches and jumps, freezes the whole front end while memory is busy, and keeps saturating stall and flush counters.

## Interface
Parameters:
- XLEN, 32: width of the performance counters.

Ports:
- clk_HZD  input  1  clock; all state updates on the falling edge, the same edge the pipeline registers use.
- rstn_HZD  input  1  asynchronous, active-low reset.
- valid_ID  input  1  the instruction in ID is real (not a bubble).
- Rs1_addr_ID  input  5  source register 1 of the ID instruction.
- Rs2_addr_ID  input  5  source register 2 of the ID instruction.
- Rs1_used_ID  input  1  the ID instruction reads Rs1.
- Rs2_used_ID  input  1  the ID instruction reads Rs2.
- Rd_addr_ID  input  5  destination register of the ID instruction.
- RegWrite_ID  input  1  the ID instruction writes Rd.
- redirect_EX  input  1  taken branch or jump resolved in EX this cycle.
- mem_busy  input  1  data or instruction memory wait; freeze request.
- en_PC  output  1  PC update enable.
- en_IFID  output  1  IF/ID register enable.
- NOP_IFID  output  1  load a bubble into IF/ID.
- en_IDEX  output  1  ID/EX register enable.
- NOP_IDEX  output  1  load a bubble into ID/EX.
- raw_hazard  output  1  a RAW hazard was detected this cycle (debug).
- stall_cnt  output  XLEN  cycles lost to RAW stalls, saturating.
- flush_cnt  output  XLEN  redirect flush events, saturating.

## Operation
**Scoreboard.** The scoreboard has three entries, sb_EX, sb_MEM and sb_WB. Each entry holds {v, rd[4:0]}.

**Hazard match.**
- A source matches an entry when the source is used, its address is non-zero, the entry's v is 1, and the entry's rd equals the source address.
- raw_hazard = valid_ID and (a match against sb_EX or sb_MEM, or sb_WB when HZD_WB_CHECK_EN is defined).

**Output priority.** Conditions are checked from highest to lowest; only the highest that applies takes effect.
1. mem_busy = 1: freeze.
   - en_PC, en_IFID and en_IDEX are 0.
   - NOP_IFID and NOP_IDEX are 0.
   - The scoreboard and counters hold.
2. redirect_EX = 1: flush.
   - en_PC, en_IFID and en_IDEX are 1.
   - NOP_IFID and NOP_IDEX are 1.
3. raw_hazard = 1: stall.
   - en_PC and en_IFID are 0.
   - en_IDEX is 1 and NOP_IDEX is 1.
   - NOP_IFID is 0.
4. Otherwise, normal flow: all enables are 1 and all NOPs are 0.

**Scoreboard update** on each falling edge, when not frozen:
- sb_WB takes sb_MEM, and sb_MEM takes sb_EX.
- sb_EX takes {valid_ID & RegWrite_ID & (Rd_addr_ID != 0), Rd_addr_ID}.
- In the flush and stall cases, sb_EX.v is 0 instead, because a bubble enters EX.

**Counters.**
- stall_cnt increments on each falling edge in the stall case.
- flush_cnt increments on each falling edge in the flush case.
- Both saturate at all-ones and do not wrap.
- A redirect that coincides with a hazard counts as a flush only.

**Register x0** never causes a hazard, whether it is a source or a destination.

## Timing
**Outputs.**
- All control outputs are combinational from the scoreboard and the current ID, EX and memory inputs.
- They are stable before the falling edge that the pipeline registers sample.

**Reset.**
- Asserting rstn_HZD low clears every scoreboard v bit and both counters immediately, without waiting for a clock edge.
- While reset is low: en_PC, en_IFID and en_IDEX are 1; NOP_IFID, NOP_IDEX and raw_hazard are 0. This is regardless of the other inputs.
- Deassertion takes effect at the next falling edge.

**Stall latency.** For a producer directly followed by a dependent instruction:
- 2 stall cycles: the dependent issues when the producer reaches WB, relying on the register file writing before it is read.
- 3 stall cycles when HZD_WB_CHECK_EN is defined.

**Redirect.**
- A redirect costs 2 bubbles: the wrong-path instructions in IF/ID and ID/EX.
- A redirect during a stall cancels the stall in that same cycle.

**Simultaneous events.**
- mem_busy together with a redirect: the freeze wins. The redirect must be held by EX, which is frozen too, and is applied on the first cycle without mem_busy.
- Reset asserted in the middle of a stall ends the stall at once.

## Configuration
Macro: HZD_WB_CHECK_EN.
- Defined: the sb_WB entry takes part in hazard matching. Use this for a register file without write-before-read.
- Undefined: sb_WB is still tracked, but it never generates a hazard.

## Test plan
- `addi x5,x0,1` then `add x6,x5,x5` → raw_hazard is 1 for 2 cycles (3 with the macro). During that time en_PC=0, NOP_IDEX=1. Then add issues, and stall_cnt=2 (3 with the macro).
- `addi x0,x0,1` then `add x6,x0,x0` → no stall; stall_cnt stays 0.
- redirect_EX pulsed for 1 cycle → NOP_IFID=NOP_IDEX=1 for that cycle only; flush_cnt=1; sb_EX.v=0 after the edge.
- A hazard pending while mem_busy is held for 4 cycles → all enables are 0, stall_cnt does not change, and the scoreboard holds. After release the stall resumes with the same remaining count.
- redirect_EX and a RAW hazard in the same cycle → flush outputs are driven; flush_cnt increments and stall_cnt does not.
- stall_cnt preloaded to 0xFFFFFFFE with 3 stall cycles → it stops at 0xFFFFFFFF. Pulling rstn_HZD low between clock edges → counters read 0 and the enables read 1 at once.
